// File: rtl/softmax_pkg.sv
// Shared types and default sizing for the softmax datapath.
package softmax_pkg;

  // Defaults shared with the exponent-approximation stage
  localparam int unsigned DEF_BITWIDTH  = 16;
  localparam int unsigned DEF_VEC_LEN   = 8;
  localparam int unsigned DEF_FRAC_BITS = 8;

  // Normalizer control states
  typedef enum logic [1:0] {
    FILL = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Accumulator width large enough that VEC_LEN full-scale elements never overflow
  function automatic int unsigned sum_width(input int unsigned bitwidth,
                                            input int unsigned vec_len);
    return bitwidth + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/softmax_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// The divisor and dividend are read live every cycle and must stay stable
// from the start pulse until done. A zero divisor yields a zero quotient.
module softmax_divider
  import softmax_pkg::*;
#(
  parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned SUM_W     = sum_width(DEF_BITWIDTH, DEF_VEC_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BITWIDTH+FRAC_BITS-1:0] dividend,
  input  logic [SUM_W-1:0]              divisor,
  output logic                          done,
  output logic [BITWIDTH-1:0]           quotient
);

  localparam int unsigned DW    = BITWIDTH + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(DW);
  localparam int unsigned QW    = BITWIDTH - 1;

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] rem;
  logic [QW-1:0]    q_work;

  logic [CNT_W-1:0] bit_sel;
  logic [SUM_W:0]   rem_shift;
  logic             q_bit;

  // Trial subtraction for the current dividend bit
  always_comb begin
    bit_sel   = CNT_W'(DW - 1) - cnt;
    rem_shift = {rem, dividend[bit_sel]};
    q_bit     = (rem_shift >= {1'b0, divisor});
  end

  // Iteration state; done marks the cycle whose edge commits the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      q_work   <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem    <= '0;
      q_work <= '0;
      done   <= 1'b0;
    end else if (active) begin
      rem    <= q_bit ? SUM_W'(rem_shift - {1'b0, divisor}) : rem_shift[SUM_W-1:0];
      q_work <= QW'({q_work, q_bit});
      cnt    <= cnt + CNT_W'(1);
      done   <= (cnt == CNT_W'(DW - 2));
      if (done) begin
        active   <= 1'b0;
        cnt      <= '0;
        rem      <= '0;
        quotient <= (divisor == '0) ? '0 : {q_work, q_bit};
      end
    end
  end

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax normalization stage: buffers a vector of e^p values, accumulates
// their sum, then streams out each element divided by the sum as an
// unsigned Q(BITWIDTH-FRAC_BITS).FRAC_BITS probability.
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
  parameter int unsigned VEC_LEN   = DEF_VEC_LEN,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned SUM_W = sum_width(BITWIDTH, VEC_LEN);
  localparam int unsigned DW    = BITWIDTH + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(VEC_LEN);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    idx;
  logic [SUM_W-1:0]    sum;
  logic [BITWIDTH-1:0] elem_buf [VEC_LEN];

  logic          in_fire_c;
  logic          out_fire_c;
  logic          last_in_c;
  logic          last_out_c;
  logic          div_start_c;
  logic [DW-1:0] dividend_c;
  logic          div_done;

  // Handshake qualifiers and divider launch; in_ready is high exactly in FILL
  always_comb begin
    in_fire_c   = in_valid && in_ready;
    out_fire_c  = out_valid && out_ready;
    last_in_c   = (cnt == CNT_W'(VEC_LEN - 1));
    last_out_c  = (idx == CNT_W'(VEC_LEN - 1));
    div_start_c = ((state == FILL) && in_fire_c && last_in_c) ||
                  ((state == OUT) && out_fire_c && !last_out_c);
    dividend_c  = DW'(elem_buf[idx]) << FRAC_BITS;
  end

  softmax_divider #(
    .BITWIDTH  (BITWIDTH),
    .FRAC_BITS (FRAC_BITS),
    .SUM_W     (SUM_W)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (dividend_c),
    .divisor  (sum),
    .done     (div_done),
    .quotient (out_data)
  );

  // Control FSM, buffer, accumulator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      idx       <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(VEC_LEN); i++) begin
        elem_buf[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_fire_c) begin
            elem_buf[cnt] <= in_data;
            sum           <= sum + SUM_W'(in_data);
            busy          <= 1'b1;
            if (last_in_c) begin
              cnt      <= '0;
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= DIV;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DIV: begin
          if (div_done) begin
            out_valid <= 1'b1;
            out_last  <= last_out_c;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_fire_c) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_out_c) begin
              sum      <= '0;
              idx      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= FILL;
            end else begin
              idx   <= idx + CNT_W'(1);
              state <= DIV;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed and randomized bench for softmax_normalizer (VEC_LEN=4, BITWIDTH=16, FRAC_BITS=8).
module tb_softmax_normalizer;

  localparam int VL         = 4;
  localparam int BW         = 16;
  localparam int FB         = 8;
  localparam int DIV_CYCLES = BW + FB;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int checks;
  int errors;

  logic [BW-1:0] vec [VL];

  softmax_normalizer #(
    .BITWIDTH  (BW),
    .VEC_LEN   (VL),
    .FRAC_BITS (FB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: probability = floor(elem * 2^FB / sum), zero when the sum is zero
  function automatic logic [BW-1:0] ref_prob(input longint unsigned e, input longint unsigned s);
    if (s == 0) return '0;
    return BW'((e * (64'd1 << FB)) / s);
  endfunction

  task automatic feed_inputs();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    for (int i = 0; i < VL; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      check("in_ready_fill", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Send one vector and check every output; bp_idx selects an element to stall for 5 cycles
  task automatic run_vec(input int bp_idx);
    longint unsigned s;
    int              cyc;
    logic [BW-1:0]   exp_d;
    s = 0;
    for (int i = 0; i < VL; i++) s += longint'(vec[i]);
    feed_inputs();
    check("in_ready_drop", 32'(in_ready), 32'd0);
    check("busy_after_fill", 32'(busy), 32'd1);
    // upstream keeps offering junk while blocked; it must be ignored
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    for (int i = 0; i < VL; i++) begin
      cyc = 0;
      while (!out_valid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("latency", 32'(cyc), 32'(DIV_CYCLES));
      exp_d = ref_prob(longint'(vec[i]), s);
      check("out_data", 32'(out_data), 32'(exp_d));
      check("out_last", 32'(out_last), 32'(i == VL - 1));
      if (i == bp_idx) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_data", 32'(out_data), 32'(exp_d));
          check("bp_last", 32'(out_last), 32'(i == VL - 1));
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      if (i == VL - 1) begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      @(posedge clk); #1;
      check("valid_after_hs", 32'(out_valid), 32'd0);
      if (i == VL - 1) begin
        check("in_ready_rise", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  task automatic no_spurious_valid();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("no_spurious_valid", 32'(seen), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    check("reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    vec = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_vec(-1);
    vec = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_vec(-1);
    vec = '{16'd100, 16'd0, 16'd0, 16'd0};
    run_vec(-1);
    vec = '{16'd0, 16'd0, 16'd0, 16'd0};
    run_vec(-1);
    vec = '{16'd65535, 16'd65535, 16'd65535, 16'd65535};
    run_vec(-1);
    vec = '{16'd3, 16'd1, 16'd0, 16'd0};
    run_vec(-1);
    vec = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_vec(1);

    // reset after two of four inputs
    in_valid = 1'b1;
    in_data  = 16'd5;
    @(posedge clk); #1;
    in_data  = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_mid_fill", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_fill");
    #2 rst_n = 1'b1;
    no_spurious_valid();
    vec = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_vec(-1);

    // reset while dividing
    vec = '{16'd9, 16'd9, 16'd9, 16'd9};
    feed_inputs();
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid_div", 32'(busy), 32'd1);
    check("valid_mid_div", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_div");
    #2 rst_n = 1'b1;
    no_spurious_valid();
    vec = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_vec(-1);

    // randomized vectors against the reference
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < VL; i++) begin
        case ($urandom_range(0, 2))
          0:       vec[i] = BW'($urandom_range(0, 65535));
          1:       vec[i] = BW'($urandom_range(0, 15));
          default: vec[i] = (i == 0) ? BW'($urandom_range(1000, 65535)) : BW'($urandom_range(0, 3));
        endcase
      end
      run_vec((r % 2 == 0) ? int'($urandom_range(0, VL - 1)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_normalizer.md
# softmax_normalizer

Streaming normalization stage of the softmax datapath. It sits directly downstream of the exponent-approximation stage and consumes one approximated e^p value per accepted beat. It buffers a fixed-length vector of those values and accumulates their sum. It then emits each element divided by the sum as an unsigned fixed-point probability, with valid/ready handshakes on both sides.

## Interface
- BITWIDTH, 16: width of each input exponent value and each output probability.
- VEC_LEN, 8: elements per softmax vector; must be ≥ 2.
- FRAC_BITS, 8: fractional bits of the output (Q(BITWIDTH-FRAC_BITS).FRAC_BITS); must be ≤ BITWIDTH-1.
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data holds an exponent value.
- in_ready  output  1  block can accept an element.
- in_data  input  BITWIDTH  unsigned e^p value from the exponent stage.
- out_valid  output  1  out_data holds a probability.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  BITWIDTH  unsigned quotient (elem << FRAC_BITS) / sum.
- out_last  output  1  high with out_valid on element VEC_LEN-1.
- busy  output  1  high whenever state ≠ FILL or fill count ≠ 0.

## Operation
- SUM_W = BITWIDTH + $clog2(VEC_LEN); the accumulator never overflows.
- The FSM has three states: FILL, DIV and OUT.
- FILL:
  - in_ready = 1.
  - Each in_valid&&in_ready beat writes buf[cnt], adds in_data to sum and increments cnt.
  - On the beat with cnt == VEC_LEN-1, go to DIV with idx = 0 and cnt cleared.
- DIV:
  - in_ready = 0.
  - Restoring division of {buf[idx], FRAC_BITS zeros} by sum takes DIV_CYCLES = BITWIDTH+FRAC_BITS cycles, one quotient bit per cycle, MSB first.
  - After the final bit, go to OUT.
- OUT:
  - out_valid = 1 with out_data = quotient and out_last = (idx == VEC_LEN-1).
  - On out_valid&&out_ready: if idx == VEC_LEN-1, clear sum and go to FILL; otherwise increment idx and go to DIV.
- Quotient range is 0..2^FRAC_BITS (equal to 2^FRAC_BITS only when one element holds the entire sum). It is zero-extended to BITWIDTH, so no saturation is needed.
- Sum of zero: the divider still runs DIV_CYCLES cycles but its quotient is forced to 0, so every output is 0 with unchanged timing.
- Inputs are unsigned; there are no signed-input semantics.

## Timing
- Reset values:
  - State FILL; cnt, idx, sum and divider registers all 0.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- Latency: the last input is accepted at edge t; DIV runs edges t+1..t+DIV_CYCLES; out_valid is high from the cycle after edge t+DIV_CYCLES.
- Every later element appears DIV_CYCLES cycles after the previous output handshake.
- Minimum vector period is VEC_LEN·(1 + DIV_CYCLES + 1) cycles with out_ready held at 1.
- in_ready drops in the cycle after the last input is accepted and rises in the cycle after the out_last handshake.
- There is no input/output overlap across vectors.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and no internal state advances.
- Reset asserted mid-fill, mid-divide or mid-output:
  - Everything returns to reset values immediately, asynchronously.
  - The partial vector is discarded, with no spurious out_valid.
- in_valid while in_ready = 0 is ignored; upstream must hold the data.

## Structure
- Package softmax_pkg holds:
  - the state typedef (enum FILL/DIV/OUT);
  - a function computing SUM_W;
  - default BITWIDTH/VEC_LEN/FRAC_BITS constants shared with the exponent stage.
- Sub-module softmax_divider is the iterative restoring divider.
  - Ports: start, dividend [BITWIDTH+FRAC_BITS], divisor [SUM_W], done, quotient [BITWIDTH].
  - It handles the zero-divisor case internally.
- The top module holds the buffer (VEC_LEN×BITWIDTH registers), the accumulator, the counters and the FSM.

## Test plan
All scenarios use VEC_LEN=4, BITWIDTH=16 and FRAC_BITS=8, so DIV_CYCLES = 24.
- Inputs 1,1,1,1 -> outputs 64,64,64,64; out_last only on the 4th; first out_valid exactly 24 cycles after the last input edge.
- Inputs 1,2,3,4 (sum 10) -> outputs 25,51,76,102.
- Inputs 100,0,0,0 -> outputs 256,0,0,0. Inputs 0,0,0,0 -> outputs 0,0,0,0 with normal timing.
- Inputs 65535 ×4 (sum 262140, no overflow) -> outputs 64 ×4. Then the next vector 3,1,0,0 -> outputs 192,64,0,0, confirming the sum was cleared.
- Vector 1,2,3,4 with out_ready low for 5 cycles on the 2nd output -> out_data stays 51 throughout, in_ready stays 0, and the remaining outputs are unchanged.
- rst_n pulsed low after 2 of 4 inputs, and separately during DIV -> in_ready = 1, out_valid = 0 and busy = 0 immediately. The next full vector 1,1,1,1 then yields 64 ×4.
